// File: rtl/ex_mc_pkg.sv
// ex_mc_pkg: shared op codes, result-class codes and FSM state type for the
// multi-cycle execute stage (ex_mc) and its iterative mul/div unit.
//
// Contents:
//   EXE_*_OP   8-bit aluop codes (logic, shift, add/sub/compare, MULT, DIVU)
//   EXE_RES_*  3-bit alusel result classes (LOGIC, SHIFT, ARITH, MULDIV)
//   state_t    ex_mc control FSM state
package ex_mc_pkg;

  // aluop codes
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_MULT_OP = 8'b0001_1000;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // alusel result classes
  localparam logic [2:0] EXE_RES_NOP    = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC  = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT  = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH  = 3'b100;
  localparam logic [2:0] EXE_RES_MULDIV = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

endpackage

// File: rtl/ex_mc_if.sv
// ex_mc_if: ID/EX input handshake plus EX/MEM output handshake of ex_mc.
//
// Signals:
//   in_valid/in_ready            op handshake from ID
//   aluop_i, alusel_i            decoded op and result class
//   reg1_i, reg2_i               operands (reg1_i also carries shift amount)
//   wd_i, wreg_i                 destination register and write enable
//   out_valid/out_ready          result handshake toward EX/MEM
//   wdata_o, wd_o, wreg_o        registered result and writeback control
//   busy_o                       iterative op in progress
// Modports: slave = the execute stage, master = the surrounding pipeline.
interface ex_mc_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            aluop_i;
  logic [2:0]            alusel_i;
  logic [DATA_W-1:0]     reg1_i;
  logic [DATA_W-1:0]     reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     wdata_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic                  busy_o;

  modport slave (
    input  in_valid, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, out_ready,
    output in_ready, out_valid, wdata_o, wd_o, wreg_o, busy_o
  );

  modport master (
    output in_valid, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, out_ready,
    input  in_ready, out_valid, wdata_o, wd_o, wreg_o, busy_o
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative 1-bit-per-cycle unit for ex_mc.
//   - shift-add multiplier, result = low DATA_W bits of op_a * op_b
//   - restoring unsigned divider (only when EX_DIV_EN is defined),
//     result = op_a / op_b, all-ones on divide by zero
// Configuration macro: EX_DIV_EN (adds the div port and divider datapath).
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   kill       synchronous abort of the running op
//   start      load operands and begin DATA_W iterations
//   div        (EX_DIV_EN only) 1 = divide, 0 = multiply
//   op_a/op_b  multiplicand/multiplier, or dividend/divisor
//   done       one-cycle pulse once all DATA_W steps have been taken
//   result     product or quotient, valid while done is high
module ex_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              start,
`ifdef EX_DIV_EN
  input  logic              div,
`endif
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  // acc: product accumulator / partial remainder
  // x:   multiplier shifted right / dividend shifted out as quotient shifts in
  // y:   multiplicand shifted left / constant divisor
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;

  assign done = running && (cnt == CNT_W'(DATA_W));

`ifdef EX_DIV_EN
  logic          div_q;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Restoring step: bring in the next dividend bit and try subtracting the
  // divisor. A zero divisor never borrows, so every quotient bit becomes 1.
  always_comb begin
    shifted = {acc, x[DATA_W-1]};
    diff    = shifted - {1'b0, y};
  end

  assign result = div_q ? x : acc;
`else
  assign result = acc;
`endif

  // NOTE: every register here, operands included, is reset so an op abandoned
  // by reset leaves no stale state behind; the cost is a handful of flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
`ifdef EX_DIV_EN
      div_q   <= 1'b0;
`endif
    end else if (kill) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      x       <= op_a;
      y       <= op_b;
`ifdef EX_DIV_EN
      div_q   <= div;
`endif
    end else if (running) begin
      if (done) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
`ifdef EX_DIV_EN
        if (div_q) begin
          if (!diff[DATA_W]) begin
            acc <= diff[DATA_W-1:0];
            x   <= {x[DATA_W-2:0], 1'b1};
          end else begin
            acc <= shifted[DATA_W-1:0];
            x   <= {x[DATA_W-2:0], 1'b0};
          end
        end else
`endif
        begin
          acc <= acc + (x[0] ? y : '0);
          y   <= y << 1;
          x   <= x >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/ex_mc.sv
// ex_mc: multi-cycle execute stage.
//   Single-cycle logic/shift/add-sub-compare ops, iterative MULT (and DIVU
//   when EX_DIV_EN is defined) through ex_muldiv_iter. The result and its
//   writeback address/enable sit in an output register with a valid/ready
//   handshake; ID is back-pressured through in_ready.
// Configuration macro: EX_DIV_EN (enables DIVU; otherwise DIVU is an unknown
//   op that returns 0 in a single cycle).
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   flush   synchronous kill of the in-flight op and the output register
//   bus     ex_mc_if.slave: input op handshake and output result handshake
module ex_mc
  import ex_mc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  ex_mc_if.slave  bus
);

  state_t                state;
  logic                  accept;
  logic                  is_iter;
  logic [DATA_W-1:0]     alu_res;
  logic [SHAMT_W-1:0]    shamt;
  logic                  it_start;
  logic                  it_done;
  logic [DATA_W-1:0]     it_result;
  logic [REG_ADDR_W-1:0] pend_wd;
  logic                  pend_wreg;

  assign shamt = bus.reg1_i[SHAMT_W-1:0];

  // A new op may enter only when idle and the output register is free or is
  // being drained this very cycle.
  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign it_start     = accept && is_iter;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    is_iter = 1'b0;
    if (bus.alusel_i == EXE_RES_MULDIV) begin
      if (bus.aluop_i == EXE_MULT_OP) is_iter = 1'b1;
`ifdef EX_DIV_EN
      if (bus.aluop_i == EXE_DIVU_OP) is_iter = 1'b1;
`endif
    end
  end

  // Single-cycle datapath; unknown class/op combinations yield 0.
  always_comb begin
    alu_res = '0;
    case (bus.alusel_i)
      EXE_RES_LOGIC: begin
        case (bus.aluop_i)
          EXE_OR_OP:  alu_res = bus.reg1_i | bus.reg2_i;
          EXE_AND_OP: alu_res = bus.reg1_i & bus.reg2_i;
          EXE_NOR_OP: alu_res = ~(bus.reg1_i | bus.reg2_i);
          EXE_XOR_OP: alu_res = bus.reg1_i ^ bus.reg2_i;
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (bus.aluop_i)
          EXE_SLL_OP: alu_res = bus.reg2_i << shamt;
          EXE_SRL_OP: alu_res = bus.reg2_i >> shamt;
          EXE_SRA_OP: alu_res = $unsigned($signed(bus.reg2_i) >>> shamt);
          default:    alu_res = '0;
        endcase
      end
      EXE_RES_ARITH: begin
        case (bus.aluop_i)
          EXE_ADD_OP:  alu_res = bus.reg1_i + bus.reg2_i;
          EXE_SUB_OP:  alu_res = bus.reg1_i - bus.reg2_i;
          EXE_SLT_OP:  alu_res = DATA_W'($signed(bus.reg1_i) < $signed(bus.reg2_i));
          EXE_SLTU_OP: alu_res = DATA_W'(bus.reg1_i < bus.reg2_i);
          default:     alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  ex_muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (it_start),
`ifdef EX_DIV_EN
    .div    (bus.aluop_i == EXE_DIVU_OP),
`endif
    .op_a   (bus.reg1_i),
    .op_b   (bus.reg2_i),
    .done   (it_done),
    .result (it_result)
  );

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus.busy_o    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.wdata_o   <= '0;
      bus.wd_o      <= '0;
      bus.wreg_o    <= 1'b0;
      pend_wd       <= '0;
      pend_wreg     <= 1'b0;
    end else if (flush) begin
      // flush beats both a concurrent accept and a concurrent drain
      state         <= IDLE;
      bus.busy_o    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      // Drained result leaves unless a new one is loaded below.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_iter) begin
              state      <= ITER;
              bus.busy_o <= 1'b1;
              pend_wd    <= bus.wd_i;
              pend_wreg  <= bus.wreg_i;
            end else begin
              bus.out_valid <= 1'b1;
              bus.wdata_o   <= alu_res;
              bus.wd_o      <= bus.wd_i;
              bus.wreg_o    <= bus.wreg_i;
            end
          end
        end
        ITER: begin
          // The output register is necessarily empty here: it was free at
          // accept and nothing else loads it while iterating.
          if (it_done) begin
            state         <= IDLE;
            bus.busy_o    <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.wdata_o   <= it_result;
            bus.wd_o      <= pend_wd;
            bus.wreg_o    <= pend_wreg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc: scoreboard bench for ex_mc (DATA_W=32, REG_ADDR_W=5).
// Stimulus pushes expected results into a queue; a monitor on the falling
// edge pops and compares every accepted output. Directed checks cover reset,
// latency, back-pressure hold, flush and reset mid-iteration.
// DIVU cases run only when EX_DIV_EN is defined.
module tb_ex_mc;
  import ex_mc_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct {
    string       name;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_mc_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  ex_mc #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every transferred result must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got wdata 0x%08h, expected no output", bus.wdata_o);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_wdata"}, bus.wdata_o, e.wdata);
        check({e.name, "_wd"}, 32'(bus.wd_o), 32'(e.wd));
        check({e.name, "_wreg"}, 32'(bus.wreg_o), 32'(e.wreg));
      end
    end
  end

  // Present an op, wait (bounded) for acceptance, optionally expect a result.
  task automatic issue(input string name, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg,
                       input bit expect_out, input logic [31:0] exp_data);
    int n = 0;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: got in_ready low for %0d cycles, expected acceptance", name, n);
      bus.in_valid = 1'b0;
      return;
    end
    if (expect_out) sb_q.push_back('{name, exp_data, wd, wreg});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Called right after an iterative op is accepted: counts cycles until
  // out_valid, requiring busy_o=1 and in_ready=0 the whole time.
  task automatic wait_iter(input string name);
    int lat = 0;
    int bad = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready || !bus.busy_o) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd33);
    check({name, "_busy_ready_bad_cycles"}, 32'(bad), 32'd0);
    check({name, "_busy_clear"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({name, "_wdata"}, bus.wdata_o, 32'd0);
    check({name, "_wd"}, 32'(bus.wd_o), 32'd0);
    check({name, "_wreg"}, 32'(bus.wreg_o), 32'd0);
  endtask

  task automatic expect_silence(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check({name, "_no_output"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.aluop_i   = '0;
    bus.alusel_i  = '0;
    bus.reg1_i    = '0;
    bus.reg2_i    = '0;
    bus.wd_i      = '0;
    bus.wreg_i    = 1'b0;

    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single-cycle ops, back to back
    issue("or", EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 1'b1, 1, 32'hF0F0_0F0F);
    check("or_latency", 32'(bus.out_valid), 32'd1);
    issue("and", EXE_AND_OP, EXE_RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4, 1'b1, 1, 32'h0F00_0F00);
    issue("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd5, 1'b0, 1, 32'h5555_5555);
    issue("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd6, 1'b1, 1, 32'hFF00_0000);
    issue("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1, 1, 32'hF800_0001);
    issue("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'h25, 32'h1234_5678, 5'd8, 1'b1, 1, 32'h468A_CF00);
    issue("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd8, 32'h8000_0000, 5'd9, 1'b1, 1, 32'h0080_0000);
    issue("add_wrap", EXE_ADD_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd10, 1'b1, 1, 32'd1);
    issue("slt", EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd11, 1'b1, 1, 32'd1);
    issue("sltu", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd12, 1'b1, 1, 32'd0);
    issue("bad_op", 8'hFF, EXE_RES_LOGIC, 32'h1234_5678, 32'hFFFF_FFFF, 5'd13, 1'b0, 1, 32'd0);
    issue("bad_sel", EXE_OR_OP, 3'b110, 32'h1234_5678, 32'h1, 5'd14, 1'b1, 1, 32'd0);
`ifndef EX_DIV_EN
    issue("divu_off", EXE_DIVU_OP, EXE_RES_MULDIV, 32'd100, 32'd7, 5'd15, 1'b1, 1, 32'd0);
    check("divu_off_latency", 32'(bus.out_valid), 32'd1);
`endif

    // Iterative multiply
    issue("mul", EXE_MULT_OP, EXE_RES_MULDIV, 32'h0001_0003, 32'h0000_0005, 5'd16, 1'b1, 1, 32'h0005_000F);
    wait_iter("mul");
    issue("mul_ones", EXE_MULT_OP, EXE_RES_MULDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b0, 1, 32'd1);
    issue("mul_zero", EXE_MULT_OP, EXE_RES_MULDIV, 32'hDEAD_BEEF, 32'd0, 5'd18, 1'b1, 1, 32'd0);
    wait_iter("mul_zero");

    // Back-pressure: result held, input blocked, resumes on release
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue("sub", EXE_SUB_OP, EXE_RES_ARITH, 32'd3, 32'd5, 5'd19, 1'b1, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_wdata", bus.wdata_o, 32'hFFFF_FFFE);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("hold_wd", 32'(bus.wd_o), 32'd19);
    bus.out_ready = 1'b1;
    #1 check("release_in_ready", 32'(bus.in_ready), 32'd1);
    issue("after_hold", EXE_ADD_OP, EXE_RES_ARITH, 32'd10, 32'd20, 5'd20, 1'b1, 1, 32'd30);

    // Flush on cycle 10 of a multiply
    issue("mul_flushed", EXE_MULT_OP, EXE_RES_MULDIV, 32'd7, 32'd9, 5'd21, 1'b1, 0, 32'd0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    #1 check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    expect_silence("flush_mul", 40);
    issue("and_after_flush", EXE_AND_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h1234_5678, 5'd22, 1'b1, 1, 32'h1234_0000);

    // Flush drops a held result
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue("or_flushed", EXE_OR_OP, EXE_RES_LOGIC, 32'h1, 32'h2, 5'd23, 1'b1, 0, 32'd0);
    check("held_before_flush", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_drops_held", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;

    // Flush and op presented together: op dropped
    bus.aluop_i  = EXE_ADD_OP;
    bus.alusel_i = EXE_RES_ARITH;
    bus.reg1_i   = 32'd1;
    bus.reg2_i   = 32'd1;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check("flush_accept_drop", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a multiply
    issue("mul_reset", EXE_MULT_OP, EXE_RES_MULDIV, 32'd3, 32'd3, 5'd24, 1'b1, 0, 32'd0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("reset_mid_mul");
    @(posedge clk);
    #1 rst = 1'b1;
    expect_silence("reset_mul", 40);
    issue("add_after_reset", EXE_ADD_OP, EXE_RES_ARITH, 32'd5, 32'd6, 5'd25, 1'b1, 1, 32'd11);

`ifdef EX_DIV_EN
    issue("divu", EXE_DIVU_OP, EXE_RES_MULDIV, 32'd100, 32'd7, 5'd26, 1'b1, 1, 32'd14);
    wait_iter("divu");
    issue("divu_zero", EXE_DIVU_OP, EXE_RES_MULDIV, 32'h1234_5678, 32'd0, 5'd27, 1'b1, 1, 32'hFFFF_FFFF);
    wait_iter("divu_zero");
    issue("divu_reset", EXE_DIVU_OP, EXE_RES_MULDIV, 32'd1000, 32'd3, 5'd28, 1'b1, 0, 32'd0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("reset_mid_divu");
    @(posedge clk);
    #1 rst = 1'b1;
    expect_silence("reset_divu", 40);
`endif

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
